data_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 64-bit data memory (async read, sync write, byte addresses, 8-byte words) between the core load/store unit (port 0) and the debug/loader port (port 1). It sits directly in front of `data_mem`, performs round-robin valid/ready arbitration, and issues at most one memory access per cycle. It returns a registered one-cycle-later response per accepted transaction, rejects misaligned addresses, and keeps saturating per-port access counters.

---
 rtl/data_mem_arbiter_if.sv | 51 +++++
 rtl/data_mem_arbiter.sv | 109 ++++++++++
 tb/tb_data_mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Purpose : bus bundle between the two requesters, the arbiter and data_mem.
// Signals : req0_* core load/store port, req1_* debug/loader port,
//           mem_* single-port 64-bit data memory (async read, sync write).
// Modports: slave  - arbiter side
//           master - requester/memory side (testbench or surrounding SoC)
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [63:0]           req0_wdata;
  logic                  req0_resp_valid;
  logic                  req0_resp_err;
  logic [63:0]           req0_rdata;
  logic [15:0]           req0_count;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [63:0]           req1_wdata;
  logic                  req1_resp_valid;
  logic                  req1_resp_err;
  logic [63:0]           req1_rdata;
  logic [15:0]           req1_count;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [63:0]           mem_wdata;
  logic [63:0]           mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, req0_resp_valid, req0_resp_err, req0_rdata, req0_count,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, req1_resp_valid, req1_resp_err, req1_rdata, req1_count,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, req0_resp_valid, req0_resp_err, req0_rdata, req0_count,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, req1_resp_valid, req1_resp_err, req1_rdata, req1_count,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Purpose : round-robin arbiter sharing one 64-bit data memory between the
//           core LSU (port 0) and the debug/loader port (port 1).
// Ports   : clk  - single clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - data_mem_arbiter_if.slave (requests, responses, counters,
//                  memory drive)
// Ready and mem_* are combinational from the current requests; responses are
// registered and appear the cycle after acceptance; counters saturate.
module data_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_arbiter_if.slave  bus
);
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 16;

  logic                  ptr_q, ptr_d;
  logic                  gnt0, gnt1, granted;
  logic                  sel_we, aligned;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_port_q,  resp_port_d;
  logic                  resp_err_q,   resp_err_d;
  logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
  logic [CNT_W-1:0]      cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic                  show0, show1;

  // Grant, memory drive and next state.
  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    ptr_d        = ptr_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = ~ptr_q;
        gnt1 = ptr_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
    granted = gnt0 | gnt1;

    sel_we    = gnt1 ? bus.req1_we    : bus.req0_we;
    sel_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
    aligned   = (sel_addr[2:0] == 3'b000);

    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
    bus.mem_we     = granted & sel_we & aligned;
    bus.mem_addr   = granted ? sel_addr  : '0;
    bus.mem_wdata  = granted ? sel_wdata : '0;

    // Pointer moves to the port that was not just served.
    if (gnt0)      ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;

    resp_valid_d = granted;
    resp_port_d  = gnt1;
    resp_err_d   = granted & ~aligned;
    resp_rdata_d = (granted && aligned && !sel_we) ? bus.mem_rdata : '0;

    if (gnt0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
    if (gnt1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  // A response pending when reset arrives is suppressed in that same cycle.
  assign show0 = resp_valid_q & ~resp_port_q & ~rst;
  assign show1 = resp_valid_q &  resp_port_q & ~rst;

  assign bus.req0_resp_valid = show0;
  assign bus.req0_resp_err   = show0 & resp_err_q;
  assign bus.req0_rdata      = show0 ? resp_rdata_q : '0;
  assign bus.req0_count      = cnt0_q;

  assign bus.req1_resp_valid = show1;
  assign bus.req1_resp_err   = show1 & resp_err_q;
  assign bus.req1_rdata      = show1 ? resp_rdata_q : '0;
  assign bus.req1_count      = cnt1_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Purpose : directed self-checking bench for data_mem_arbiter with a local
//           behavioural data_mem (async read, sync write, 8-byte words).
module tb_data_mem_arbiter;
  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  data_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  data_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:511];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[AW-1:3]] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr[AW-1:3]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic [AW-1:0] a, input logic [63:0] d);
    bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic [AW-1:0] a, input logic [63:0] d);
    bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 64'h0;
    mem[0] = 64'h1;
    mem[1] = 64'h2;
    mem[3] = 64'h0123_4567_89AB_CDEF;
    set0(1'b1, 1'b0, 12'h000, 64'h0);
    set1(1'b0, 1'b0, 12'h000, 64'h0);

    // Reset: nothing accepted, registered outputs cleared.
    tick(); tick();
    chk("rst_ready0", 64'(bus.req0_ready), 64'h0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'h0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    chk("rst_resp_valid0", 64'(bus.req0_resp_valid), 64'h0);
    chk("rst_resp_valid1", 64'(bus.req1_resp_valid), 64'h0);
    chk("rst_count0", 64'(bus.req0_count), 64'h0);
    chk("rst_count1", 64'(bus.req1_count), 64'h0);

    // Single read of 0x000.
    rst = 1'b0;
    #1;
    chk("rd0_ready0", 64'(bus.req0_ready), 64'h1);
    chk("rd0_ready1", 64'(bus.req1_ready), 64'h0);
    tick();
    set0(1'b0, 1'b0, 12'h000, 64'h0);
    chk("rd0_resp_valid0", 64'(bus.req0_resp_valid), 64'h1);
    chk("rd0_rdata0", bus.req0_rdata, 64'h1);
    chk("rd0_err0", 64'(bus.req0_resp_err), 64'h0);
    chk("rd0_resp_valid1", 64'(bus.req1_resp_valid), 64'h0);
    chk("rd0_count0", 64'(bus.req0_count), 64'h1);

    // Fairness after a fresh reset: grants 0,1,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set0(1'b1, 1'b0, 12'h008, 64'h0);
    set1(1'b1, 1'b0, 12'h018, 64'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_ready0", i), 64'(bus.req0_ready), 64'((i % 2) == 0));
      chk($sformatf("rr%0d_ready1", i), 64'(bus.req1_ready), 64'((i % 2) == 1));
      tick();
      if ((i % 2) == 0) begin
        chk($sformatf("rr%0d_valid0", i), 64'(bus.req0_resp_valid), 64'h1);
        chk($sformatf("rr%0d_rdata0", i), bus.req0_rdata, 64'h2);
        chk($sformatf("rr%0d_valid1", i), 64'(bus.req1_resp_valid), 64'h0);
      end else begin
        chk($sformatf("rr%0d_valid1", i), 64'(bus.req1_resp_valid), 64'h1);
        chk($sformatf("rr%0d_rdata1", i), bus.req1_rdata, 64'h0123_4567_89AB_CDEF);
        chk($sformatf("rr%0d_valid0", i), 64'(bus.req0_resp_valid), 64'h0);
      end
    end
    chk("rr_count0", 64'(bus.req0_count), 64'h2);
    chk("rr_count1", 64'(bus.req1_count), 64'h2);

    // Port 1 write then port 0 read-after-write.
    set0(1'b0, 1'b0, 12'h000, 64'h0);
    set1(1'b1, 1'b1, 12'h020, 64'hDEAD_BEEF_CAFE_F00D);
    #1;
    chk("wr_ready1", 64'(bus.req1_ready), 64'h1);
    chk("wr_mem_we", 64'(bus.mem_we), 64'h1);
    chk("wr_mem_addr", 64'(bus.mem_addr), 64'h020);
    chk("wr_mem_wdata", bus.mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    set1(1'b0, 1'b0, 12'h000, 64'h0);
    set0(1'b1, 1'b0, 12'h020, 64'h0);
    chk("wr_resp_valid1", 64'(bus.req1_resp_valid), 64'h1);
    chk("wr_err1", 64'(bus.req1_resp_err), 64'h0);
    chk("wr_rdata1", bus.req1_rdata, 64'h0);
    #1;
    chk("raw_ready0", 64'(bus.req0_ready), 64'h1);
    tick();
    chk("raw_resp_valid0", 64'(bus.req0_resp_valid), 64'h1);
    chk("raw_rdata0", bus.req0_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("raw_count1", 64'(bus.req1_count), 64'h3);

    // Misaligned write: accepted, no memory write, error response.
    set0(1'b1, 1'b1, 12'h00C, 64'hA5A5_A5A5_A5A5_A5A5);
    #1;
    chk("mis_ready0", 64'(bus.req0_ready), 64'h1);
    chk("mis_mem_we", 64'(bus.mem_we), 64'h0);
    tick();
    set0(1'b1, 1'b0, 12'h008, 64'h0);
    chk("mis_resp_valid0", 64'(bus.req0_resp_valid), 64'h1);
    chk("mis_err0", 64'(bus.req0_resp_err), 64'h1);
    chk("mis_rdata0", bus.req0_rdata, 64'h0);
    tick();
    set0(1'b0, 1'b0, 12'h000, 64'h0);
    chk("mis_after_rdata0", bus.req0_rdata, 64'h2);
    chk("mis_after_err0", 64'(bus.req0_resp_err), 64'h0);
    chk("mis_count0", 64'(bus.req0_count), 64'h5);

    // Reset right after an accepted read drops the response.
    set0(1'b1, 1'b0, 12'h000, 64'h0);
    tick();
    set0(1'b0, 1'b0, 12'h000, 64'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_valid0", 64'(bus.req0_resp_valid), 64'h0);
    chk("mid_rst_rdata0", bus.req0_rdata, 64'h0);
    tick();
    chk("mid_rst_count0", 64'(bus.req0_count), 64'h0);
    chk("mid_rst_count1", 64'(bus.req1_count), 64'h0);
    rst = 1'b0;
    set0(1'b1, 1'b0, 12'h008, 64'h0);
    set1(1'b1, 1'b0, 12'h018, 64'h0);
    #1;
    chk("post_rst_ready0", 64'(bus.req0_ready), 64'h1);
    chk("post_rst_ready1", 64'(bus.req1_ready), 64'h0);
    tick();
    chk("post_rst_ready1_next", 64'(bus.req1_ready), 64'h1);
    tick();
    set0(1'b0, 1'b0, 12'h000, 64'h0);

    // Port 1 saturation: count1 starts at 1, then 65,536 back-to-back reads.
    for (int i = 0; i < 65536; i++) tick();
    chk("sat_count1", 64'(bus.req1_count), 64'hFFFF);
    chk("sat_resp_valid1", 64'(bus.req1_resp_valid), 64'h1);
    chk("sat_rdata1", bus.req1_rdata, 64'h0123_4567_89AB_CDEF);
    tick();
    chk("sat_count1_hold", 64'(bus.req1_count), 64'hFFFF);
    chk("sat_resp_valid1_hold", 64'(bus.req1_resp_valid), 64'h1);
    chk("sat_count0", 64'(bus.req0_count), 64'h1);
    set1(1'b0, 1'b0, 12'h000, 64'h0);
    tick();
    chk("idle_resp_valid1", 64'(bus.req1_resp_valid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
